// File: rtl/prog_loader_pkg.sv
// Shared CPU package: loader FSM states and default depth, plus the core's
// opcode and ALU operation encodings used elsewhere in the datapath.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA,
        LD_DONE
    } ld_state_t;

    localparam int LD_DEPTH_WORDS = 32;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_ADDI  = 6'h01,
        OP_ORI   = 6'h10,
        OP_SW    = 6'h26,
        OP_LW    = 6'h27,
        OP_BEQ   = 6'h30,
        OP_J     = 6'h38,
        OP_HALT  = 6'h3f
    } opcode_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_SLL = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_SLT = 3'd5,
        ALU_XOR = 3'd6
    } aluop_t;

    // States in which the loader consumes bytes from the stream.
    function automatic logic ld_takes_bytes(input ld_state_t s);
        return (s == LD_LEN_HI) || (s == LD_LEN_LO) || (s == LD_DATA);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: reads a 16-bit big-endian word count, then packs
// bytes into big-endian words and writes them to instruction memory while the CPU is held.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int          DEPTH_WORDS = LD_DEPTH_WORDS,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    localparam int IW = $clog2(DEPTH_WORDS) + 1;

    ld_state_t       state, state_d;
    logic [7:0]      len_hi, len_hi_d;
    logic [IW-1:0]   last_idx, last_idx_d;
    logic [IW-1:0]   widx, widx_d;
    logic [1:0]      bcnt, bcnt_d;
    logic [31:0]     asmb, asmb_d;
    logic            in_ready_d, im_we_d, cpu_hold_d, done_d, err_d;
    logic [31:0]     im_addr_d, im_wdata_d;
    logic            hs;
    logic [15:0]     n_word;

    assign hs     = in_valid & in_ready;
    assign n_word = {len_hi, in_data};

    always_comb begin
        state_d    = state;
        len_hi_d   = len_hi;
        last_idx_d = last_idx;
        widx_d     = widx;
        bcnt_d     = bcnt;
        asmb_d     = asmb;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr;
        im_wdata_d = im_wdata;
        done_d     = 1'b0;
        err_d      = err;

        case (state)
            LD_IDLE: begin
                if (start) begin
                    state_d = LD_LEN_HI;
                    err_d   = 1'b0;
                    widx_d  = '0;
                    bcnt_d  = '0;
                    asmb_d  = '0;
                end
            end
            LD_LEN_HI: begin
                if (hs) begin
                    len_hi_d = in_data;
                    state_d  = LD_LEN_LO;
                end
            end
            LD_LEN_LO: begin
                if (hs) begin
                    if (n_word == 16'd0) begin
                        state_d = LD_DONE;
                    end else if (n_word > 16'(DEPTH_WORDS)) begin
                        err_d   = 1'b1;
                        state_d = LD_IDLE;
                    end else begin
                        last_idx_d = IW'(n_word - 16'd1);
                        state_d    = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (hs) begin
                    asmb_d = {asmb[23:0], in_data};
                    bcnt_d = bcnt + 2'd1;
                    if (bcnt == 2'd3) begin
                        im_we_d    = 1'b1;
                        im_wdata_d = {asmb[23:0], in_data};
                        im_addr_d  = BASE_ADDR + (32'(widx) << 2);
                        widx_d     = widx + IW'(1);
                        // Leave DATA on the same edge the final write is issued.
                        if (widx == last_idx)
                            state_d = LD_DONE;
                    end
                end
            end
            LD_DONE: begin
                state_d = LD_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = LD_IDLE;
        endcase

        in_ready_d = ld_takes_bytes(state_d);
        // Hold extends through the registered done pulse that follows DONE.
        cpu_hold_d = (state_d != LD_IDLE) || (state == LD_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LD_IDLE;
            len_hi   <= '0;
            last_idx <= '0;
            widx     <= '0;
            bcnt     <= '0;
            asmb     <= '0;
            in_ready <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_d;
            len_hi   <= len_hi_d;
            last_idx <= last_idx_d;
            widx     <= widx_d;
            bcnt     <= bcnt_d;
            asmb     <= asmb_d;
            in_ready <= in_ready_d;
            im_we    <= im_we_d;
            im_addr  <= im_addr_d;
            im_wdata <= im_wdata_d;
            cpu_hold <= cpu_hold_d;
            done     <= done_d;
            err      <= err_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle-by-cycle vector table plus hand-written
// gapped-stream and mid-session reset sequences.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready, im_we, cpu_hold, done, err;
    logic [31:0] im_addr, im_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    prog_loader dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r, s, vl;
        logic [7:0]  d;
        logic        rdy, we;
        logic [31:0] a, wd;
        logic        h, dn, e;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, s, vl, input logic [7:0] d,
                               input logic rdy, we, input logic [31:0] a, wd,
                               input logic h, dn, e);
        vec_t x;
        x.r = r; x.s = s; x.vl = vl; x.d = d;
        x.rdy = rdy; x.we = we; x.a = a; x.wd = wd; x.h = h; x.dn = dn; x.e = e;
        return x;
    endfunction

    task automatic step(input string nm, input vec_t x);
        @(negedge clk);
        rst = x.r; start = x.s; in_valid = x.vl; in_data = x.d;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err} !==
            {x.rdy, x.we, x.a, x.wd, x.h, x.dn, x.e}) begin
            n_bad++;
            $display("FAIL %s: got rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b, expected rdy=%b we=%b addr=%h wd=%h hold=%b done=%b err=%b",
                     nm, in_ready, im_we, im_addr, im_wdata, cpu_hold, done, err,
                     x.rdy, x.we, x.a, x.wd, x.h, x.dn, x.e);
        end
    endtask

    localparam logic [31:0] W1 = 32'h9ABCDEF0;
    localparam logic [31:0] W2 = 32'h55667788;

    initial begin
        logic [7:0] gb[4];

        // reset, then two-word load at full rate
        tbl.push_back(v(1,0,0,8'h00, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,8'h00, 0,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,8'h00, 1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h00, 1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h02, 1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h12, 1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h34, 1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h56, 1,0,0,0,1,0,0));
        tbl.push_back(v(0,0,1,8'h78, 1,1,0,32'h12345678,1,0,0));
        tbl.push_back(v(0,0,1,8'h9A, 1,0,0,32'h12345678,1,0,0));
        tbl.push_back(v(0,0,1,8'hBC, 1,0,0,32'h12345678,1,0,0));
        tbl.push_back(v(0,0,1,8'hDE, 1,0,0,32'h12345678,1,0,0));
        tbl.push_back(v(0,0,1,8'hF0, 0,1,4,W1,1,0,0));
        tbl.push_back(v(0,0,0,8'h00, 0,0,4,W1,1,1,0));
        tbl.push_back(v(0,0,0,8'h00, 0,0,4,W1,0,0,0));
        // zero-length session
        tbl.push_back(v(0,1,0,8'h00, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h00, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h00, 0,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,0,8'h00, 0,0,4,W1,1,1,0));
        tbl.push_back(v(0,0,0,8'h00, 0,0,4,W1,0,0,0));
        // overflow length 0x21, byte offered in IDLE, restart clears err
        tbl.push_back(v(0,1,0,8'h00, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h00, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h21, 0,0,4,W1,0,0,1));
        tbl.push_back(v(0,0,1,8'h55, 0,0,4,W1,0,0,1));
        tbl.push_back(v(0,1,0,8'h00, 1,0,4,W1,1,0,0));
        // start pulses mid-DATA and in DONE are ignored
        tbl.push_back(v(0,0,1,8'h00, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h02, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h11, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,1,1,8'h22, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h33, 1,0,4,W1,1,0,0));
        tbl.push_back(v(0,0,1,8'h44, 1,1,0,32'h11223344,1,0,0));
        tbl.push_back(v(0,1,1,8'h55, 1,0,0,32'h11223344,1,0,0));
        tbl.push_back(v(0,0,1,8'h66, 1,0,0,32'h11223344,1,0,0));
        tbl.push_back(v(0,0,1,8'h77, 1,0,0,32'h11223344,1,0,0));
        tbl.push_back(v(0,0,1,8'h88, 0,1,4,W2,1,0,0));
        tbl.push_back(v(0,1,0,8'h00, 0,0,4,W2,1,1,0));
        tbl.push_back(v(0,0,0,8'h00, 0,0,4,W2,0,0,0));

        foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

        // one word, each byte followed by a 3-cycle in_valid gap
        step("gap_start", v(0,1,0,8'h00, 1,0,4,W2,1,0,0));
        step("gap_lhi",   v(0,0,1,8'h00, 1,0,4,W2,1,0,0));
        step("gap_llo",   v(0,0,1,8'h01, 1,0,4,W2,1,0,0));
        gb[0] = 8'hAA; gb[1] = 8'hBB; gb[2] = 8'hCC; gb[3] = 8'hDD;
        for (int i = 0; i < 3; i++) begin
            step($sformatf("gap_b%0d", i), v(0,0,1,gb[i], 1,0,4,W2,1,0,0));
            for (int j = 0; j < 3; j++)
                step($sformatf("gap_b%0d_idle%0d", i, j), v(0,0,0,8'hFF, 1,0,4,W2,1,0,0));
        end
        step("gap_b3",    v(0,0,1,gb[3], 0,1,0,32'hAABBCCDD,1,0,0));
        step("gap_done",  v(0,0,0,8'h00, 0,0,0,32'hAABBCCDD,1,1,0));
        step("gap_idle",  v(0,0,0,8'h00, 0,0,0,32'hAABBCCDD,0,0,0));

        // reset after two bytes of word 1, then a fresh one-word session
        step("rs_start",  v(0,1,0,8'h00, 1,0,0,32'hAABBCCDD,1,0,0));
        step("rs_lhi",    v(0,0,1,8'h00, 1,0,0,32'hAABBCCDD,1,0,0));
        step("rs_llo",    v(0,0,1,8'h02, 1,0,0,32'hAABBCCDD,1,0,0));
        step("rs_w0b0",   v(0,0,1,8'h01, 1,0,0,32'hAABBCCDD,1,0,0));
        step("rs_w0b1",   v(0,0,1,8'h02, 1,0,0,32'hAABBCCDD,1,0,0));
        step("rs_w0b2",   v(0,0,1,8'h03, 1,0,0,32'hAABBCCDD,1,0,0));
        step("rs_w0b3",   v(0,0,1,8'h04, 1,1,0,32'h01020304,1,0,0));
        step("rs_w1b0",   v(0,0,1,8'h05, 1,0,0,32'h01020304,1,0,0));
        step("rs_w1b1",   v(0,0,1,8'h06, 1,0,0,32'h01020304,1,0,0));
        step("rs_assert", v(1,0,1,8'h07, 0,0,0,0,0,0,0));
        step("rs_held",   v(1,1,1,8'h08, 0,0,0,0,0,0,0));
        step("rs_rel",    v(0,0,1,8'h09, 0,0,0,0,0,0,0));
        step("rs2_start", v(0,1,0,8'h00, 1,0,0,0,1,0,0));
        step("rs2_lhi",   v(0,0,1,8'h00, 1,0,0,0,1,0,0));
        step("rs2_llo",   v(0,0,1,8'h01, 1,0,0,0,1,0,0));
        step("rs2_b0",    v(0,0,1,8'hA1, 1,0,0,0,1,0,0));
        step("rs2_b1",    v(0,0,1,8'hB2, 1,0,0,0,1,0,0));
        step("rs2_b2",    v(0,0,1,8'hC3, 1,0,0,0,1,0,0));
        step("rs2_b3",    v(0,0,1,8'hD4, 0,1,0,32'hA1B2C3D4,1,0,0));
        step("rs2_done",  v(0,0,0,8'h00, 0,0,0,32'hA1B2C3D4,1,1,0));
        step("rs2_idle",  v(0,0,0,8'h00, 0,0,0,32'hA1B2C3D4,0,0,0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH_WORDS, default 32, maximum number of 32-bit words loadable into instruction memory.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first loaded word.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-007 in_data  input  8  byte-stream payload.
REQ-008 in_ready  output  1  loader accepts in_data this cycle; handshake = in_valid & in_ready.
REQ-009 im_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 im_addr  output  32  byte address of the word being written.
REQ-011 im_wdata  output  32  word being written; big-endian, first byte received is bits [31:24].
REQ-012 cpu_hold  output  1  holds the CPU (PCWre low, PC frozen) while a session is in progress.
REQ-013 done  output  1  one-cycle pulse when a session completes successfully.
REQ-014 err  output  1  sticky flag; length overflow detected.

Function
REQ-015 States: IDLE, LEN_HI, LEN_LO, DATA, DONE; encoding is implementation's choice.
REQ-016 IDLE: in_ready=0; start=1 moves to LEN_HI, clears err, sets cpu_hold=1 from the next cycle.
REQ-017 start while not IDLE is ignored.
REQ-018 LEN_HI/LEN_LO: in_ready=1; each accepts one byte, forming the 16-bit word count N, MSB first.
REQ-019 After LEN_LO handshake: N=0 -> DONE; N>DEPTH_WORDS -> err=1, cpu_hold=0, back to IDLE, no writes; else -> DATA.
REQ-020 DATA: in_ready=1; a 2-bit byte counter shifts accepted bytes into a 32-bit assembly register.
REQ-021 On the 4th byte handshake of a word, im_we=1 in the following cycle, im_wdata = assembled word, im_addr = BASE_ADDR + 4*word_index.
REQ-022 im_we is registered; im_addr/im_wdata are stable while im_we=1 and hold their last values otherwise.
REQ-023 in_ready stays high during the im_we cycle; back-to-back bytes at full rate are sustained without loss.
REQ-024 word_index wraps never: after word N-1 is written, state moves to DONE in the cycle im_we is asserted for it.
REQ-025 DONE: lasts exactly one cycle; done=1, cpu_hold=1; next state IDLE with cpu_hold=0.
REQ-026 in_valid low stalls the session indefinitely; no timeout.
REQ-027 Bytes offered in IDLE or DONE are not accepted (in_ready=0).
REQ-028 Address arithmetic is 32-bit modulo 2^32; word_index width = clog2(DEPTH_WORDS)+1.

Reset
REQ-029 Reset asserted: state=IDLE, in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=0, done=0, err=0, counters and assembly register 0.
REQ-030 Reset mid-session aborts immediately; a partially assembled word is discarded and never written.

Structure
REQ-031 State enumeration and default DEPTH_WORDS live in the shared CPU package alongside opcode/ALUOp constants.
REQ-032 Single flat module; no sub-modules; the byte assembler is inline.
REQ-033 Outputs driven from registers only (no combinational path from in_valid to in_ready).

Verification
REQ-034 start, bytes 00 02 | 12 34 56 78 | 9A BC DE F0 back-to-back -> im_we at addr 0x0 data 0x12345678, then addr 0x4 data 0x9ABCDEF0; done pulse one cycle later; cpu_hold high start+1 through done.
REQ-035 start, length 00 00 -> no im_we, done pulses, err=0, cpu_hold deasserts after DONE.
REQ-036 DEPTH_WORDS=32, length 00 21 -> err=1, no im_we, cpu_hold=0, in_ready=0; subsequent start clears err.
REQ-037 length 00 01, bytes with in_valid gapped 3 cycles each -> single write 0xAABBCCDD at BASE_ADDR only after 4th handshake.
REQ-038 Reset asserted after 2 data bytes of word 1 -> all outputs 0 next edge, no write; fresh session loads word 0 at BASE_ADDR.
REQ-039 start pulsed mid-DATA -> ignored; word count and addresses unaffected.
